// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_if
// Description : Load/store request/response bundle between the core's MEM
//               stage (master) and the data memory responder (slave).
//               Request  : req_valid, req_ready, req_write, req_addr,
//                          req_len, req_wdata
//               Response : rsp_valid, rsp_rdata, rsp_err
//               Status   : busy (memory stall indication)
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [DEPTH-1:0] req_addr;
    logic [2:0]       req_len;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_rdata;
    logic             rsp_err;
    logic             busy;

    modport master (
        output req_valid, req_write, req_addr, req_len, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_len, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Byte-addressed little-endian data memory with a valid/ready
//               request handshake and LATENCY wait states. A request is
//               accepted in IDLE, the access is performed on the edge that
//               enters RESP, and a one-cycle response pulse returns load data
//               or an error flag.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-low reset
//               bus  - slave side of data_mem_responder_if (request,
//                      response and busy)
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int LATENCY = 2
) (
    input  wire logic            clk,
    input  wire logic            rst,
    data_mem_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] c_latency  = 4'(LATENCY);
    localparam bit         c_zero_lat = (LATENCY == 0);

    state_t           r_state;
    logic [3:0]       r_count;
    logic             r_write;
    logic [DEPTH-1:0] r_addr;
    logic [2:0]       r_len;
    logic [WIDTH-1:0] r_wdata;
    logic             r_rsp_valid;
    logic             r_rsp_err;
    logic [WIDTH-1:0] r_rsp_rdata;

    logic [7:0]       r_mem [0:(1<<DEPTH)-1];

    logic             w_accept;
    logic             w_commit;
    logic             w_src_write;
    logic [DEPTH-1:0] w_src_addr;
    logic [2:0]       w_src_len;
    logic [WIDTH-1:0] w_src_wdata;
    logic             w_len_ok;
    logic             w_misaligned;
    logic             w_err;
    logic [DEPTH-1:0] w_a1;
    logic [DEPTH-1:0] w_a2;
    logic [DEPTH-1:0] w_a3;
    logic [7:0]       w_b0;
    logic [7:0]       w_b1;
    logic [7:0]       w_b2;
    logic [7:0]       w_b3;
    logic [WIDTH-1:0] w_load_data;

    assign w_accept = (r_state == ST_IDLE) && bus.req_valid;

    // The access happens on the edge entering RESP. With zero wait states
    // that is the acceptance edge itself, so the live request is used;
    // otherwise the captured copy is. Reset blocks the commit so a request
    // presented while reset is held can never reach the array.
    assign w_commit = rst && ((c_zero_lat && w_accept) ||
                              ((r_state == ST_WAIT) && (r_count == 4'd1)));

    assign w_src_write = (r_state == ST_IDLE) ? bus.req_write : r_write;
    assign w_src_addr  = (r_state == ST_IDLE) ? bus.req_addr  : r_addr;
    assign w_src_len   = (r_state == ST_IDLE) ? bus.req_len   : r_len;
    assign w_src_wdata = (r_state == ST_IDLE) ? bus.req_wdata : r_wdata;

    // Stores only take the signed-encoded sizes; loads also take BU/HU.
    always_comb begin
        w_len_ok = 1'b0;
        case (w_src_len)
            3'b000, 3'b001, 3'b010: w_len_ok = 1'b1;
            3'b100, 3'b101:         w_len_ok = !w_src_write;
            default:                w_len_ok = 1'b0;
        endcase
    end

    // len[1:0] is the size code for both signed and unsigned encodings.
    assign w_misaligned = ((w_src_len[1:0] == 2'b01) && w_src_addr[0]) ||
                          ((w_src_len[1:0] == 2'b10) && (w_src_addr[1:0] != 2'b00));
    assign w_err        = !w_len_ok || w_misaligned;

    assign w_a1 = w_src_addr + DEPTH'(1);
    assign w_a2 = w_src_addr + DEPTH'(2);
    assign w_a3 = w_src_addr + DEPTH'(3);
    assign w_b0 = r_mem[w_src_addr];
    assign w_b1 = r_mem[w_a1];
    assign w_b2 = r_mem[w_a2];
    assign w_b3 = r_mem[w_a3];

    always_comb begin
        w_load_data = '0;
        case (w_src_len)
            3'b000:  w_load_data = {{24{w_b0[7]}}, w_b0};
            3'b001:  w_load_data = {{16{w_b1[7]}}, w_b1, w_b0};
            3'b010:  w_load_data = {w_b3, w_b2, w_b1, w_b0};
            3'b100:  w_load_data = {24'd0, w_b0};
            3'b101:  w_load_data = {16'd0, w_b1, w_b0};
            default: w_load_data = '0;
        endcase
    end

    // Control FSM and registered response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_count     <= 4'd0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_len       <= 3'd0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_write <= bus.req_write;
                        r_addr  <= bus.req_addr;
                        r_len   <= bus.req_len;
                        r_wdata <= bus.req_wdata;
                        r_count <= c_latency;
                        r_state <= c_zero_lat ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_count <= r_count - 4'd1;
                    if (r_count == 4'd1) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_commit) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (!w_src_write && !w_err) ? w_load_data : '0;
            end
        end
    end

    // Storage array: deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_commit && w_src_write && !w_err) begin
            case (w_src_len)
                3'b000: begin
                    r_mem[w_src_addr] <= w_src_wdata[7:0];
                end
                3'b001: begin
                    r_mem[w_src_addr] <= w_src_wdata[7:0];
                    r_mem[w_a1]       <= w_src_wdata[15:8];
                end
                3'b010: begin
                    r_mem[w_src_addr] <= w_src_wdata[7:0];
                    r_mem[w_a1]       <= w_src_wdata[15:8];
                    r_mem[w_a2]       <= w_src_wdata[23:16];
                    r_mem[w_a3]       <= w_src_wdata[31:24];
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire
